// File: rtl/neo_rtc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : neo_rtc_seq                                                      |
// | Brief   : uPD4990 serial RTC sequencer; shifts commands and time words,    |
// |           captures time reads. NEO_RTC_TP_IRQ_EN adds the TP interrupt.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module neo_rtc_seq #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [3:0]  CMD,
   input  logic [47:0] WDATA,
   output logic [47:0] RDATA,
   output logic        RD_VALID,
   output logic        BUSY,
   input  logic [2:0]  SW_RTCCTRL,
   input  logic        RTC_DOUT,
   input  logic        RTC_TP,
   output logic        RTC_DIN,
   output logic        RTC_CLK,
   output logic        RTC_STROBE
`ifdef NEO_RTC_TP_IRQ_EN
   ,
   output logic        TP_IRQ,
   input  logic        TP_ACK
`endif
);

   localparam logic [7:0] c_HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [5:0] c_DATA_LAST = 6'd47;
   localparam logic [5:0] c_CMD_LAST  = 6'd3;
   localparam logic [5:0] c_BIT_SAT   = 6'h3F;
   localparam logic [3:0] c_CMD_SET   = 4'd2;
   localparam logic [3:0] c_CMD_READ  = 4'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SHDATA = 3'd1,
      S_SHCMD  = 3'd2,
      S_STRB   = 3'd3,
      S_READ   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_half;
   logic        r_phase;
   logic [5:0]  r_bit;
   logic [3:0]  r_cmd;
   logic [3:0]  r_cmd_sh;
   logic [47:0] r_data_sh;
   logic [47:0] r_shadow;
   logic [47:0] r_rdata;
   logic        r_dout_meta;
   logic        r_dout_sync;

   logic        w_accept;
   logic        w_half_end;
   logic        w_slot_end;
   logic        w_sample;
   logic        w_drv_din;
   logic        w_drv_clk;
   logic        w_drv_stb;

   assign w_accept   = CMD_VALID & (r_state == S_IDLE);
   assign w_half_end = (r_half == 8'd0);
   assign w_slot_end = w_half_end & r_phase;
   // Last cycle of the low phase: DOUT has been stable for a full high phase plus sync delay.
   assign w_sample   = w_half_end & ~r_phase;

   always_comb begin
      w_state_nxt = r_state;
      w_drv_din   = 1'b0;
      w_drv_clk   = 1'b0;
      w_drv_stb   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = (CMD == c_CMD_SET) ? S_SHDATA : S_SHCMD;
            end
         end
         S_SHDATA: begin
            w_drv_din = r_data_sh[0];
            w_drv_clk = r_phase;
            if (w_slot_end && (r_bit == c_DATA_LAST)) begin
               w_state_nxt = S_SHCMD;
            end
         end
         S_SHCMD: begin
            w_drv_din = r_cmd_sh[0];
            w_drv_clk = r_phase;
            if (w_slot_end && (r_bit == c_CMD_LAST)) begin
               w_state_nxt = S_STRB;
            end
         end
         S_STRB: begin
            w_drv_stb = 1'b1;
            if (w_slot_end) begin
               w_state_nxt = (r_cmd == c_CMD_READ) ? S_READ : S_DONE;
            end
         end
         S_READ: begin
            w_drv_clk = r_phase;
            if (w_slot_end && (r_bit == c_DATA_LAST)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_state <= S_IDLE;
         r_half  <= 8'd0;
         r_phase <= 1'b0;
         r_bit   <= 6'd0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state != w_state_nxt) begin
            r_half  <= c_HALF_LAST;
            r_phase <= 1'b0;
            r_bit   <= 6'd0;
         end else if ((r_state != S_IDLE) && (r_state != S_DONE)) begin
            if (w_half_end) begin
               r_half  <= c_HALF_LAST;
               r_phase <= ~r_phase;
               if (r_phase && (r_bit != c_BIT_SAT)) begin
                  r_bit <= r_bit + 6'd1;
               end
            end else begin
               r_half <= r_half - 8'd1;
            end
         end
      end
   end

   // Command and time word are captured at accept; the inputs are free afterwards.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_cmd     <= 4'd0;
         r_cmd_sh  <= 4'd0;
         r_data_sh <= 48'd0;
      end else begin
         if (w_accept) begin
            r_cmd     <= CMD;
            r_cmd_sh  <= CMD;
            r_data_sh <= WDATA;
         end else if (w_slot_end && (r_state == S_SHDATA)) begin
            r_data_sh <= {1'b0, r_data_sh[47:1]};
         end else if (w_slot_end && (r_state == S_SHCMD)) begin
            r_cmd_sh <= {1'b0, r_cmd_sh[3:1]};
         end
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_dout_meta <= 1'b0;
         r_dout_sync <= 1'b0;
         r_shadow    <= 48'd0;
         r_rdata     <= 48'd0;
      end else begin
         r_dout_meta <= RTC_DOUT;
         r_dout_sync <= r_dout_meta;
         if (w_sample && (r_state == S_READ)) begin
            r_shadow <= {r_dout_sync, r_shadow[47:1]};
         end
         // Publish on entry to DONE so RDATA is already valid while RD_VALID is high.
         if ((r_state == S_READ) && (w_state_nxt == S_DONE)) begin
            r_rdata <= r_shadow;
         end
      end
   end

   assign RDATA     = r_rdata;
   assign CMD_READY = (r_state == S_IDLE);
   assign BUSY      = (r_state != S_IDLE);
   assign RD_VALID  = (r_state == S_DONE) && (r_cmd == c_CMD_READ);

   assign {RTC_STROBE, RTC_CLK, RTC_DIN} = (r_state == S_IDLE) ? SW_RTCCTRL
                                         : {w_drv_stb, w_drv_clk, w_drv_din};

`ifdef NEO_RTC_TP_IRQ_EN
   logic r_tp_meta;
   logic r_tp_sync;
   logic r_tp_prev;
   logic r_tp_irq;
   logic w_tp_rise;

   assign w_tp_rise = r_tp_sync & ~r_tp_prev;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_tp_meta <= 1'b0;
         r_tp_sync <= 1'b0;
         r_tp_prev <= 1'b0;
         r_tp_irq  <= 1'b0;
      end else begin
         r_tp_meta <= RTC_TP;
         r_tp_sync <= r_tp_meta;
         r_tp_prev <= r_tp_sync;
         if (w_tp_rise) begin
            r_tp_irq <= 1'b1;
         end else if (TP_ACK) begin
            r_tp_irq <= 1'b0;
         end
      end
   end

   assign TP_IRQ = r_tp_irq;
`else
   logic w_unused_tp;
   assign w_unused_tp = RTC_TP;
`endif

endmodule
`default_nettype wire
